// File: rtl/mips_exec_pkg.sv
// Shared types for the MIPS execute stage: alu_op classes, ALU control codes
// and the R-type funct field values the decoder recognises.
package mips_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_RTYPE  = 4'd1,
    OP_SUB    = 4'd2,
    OP_NE     = 4'd3,
    OP_REGIMM = 4'd4,
    OP_LEZ    = 4'd5,
    OP_GTZ    = 4'd6,
    OP_AND    = 4'd7,
    OP_OR     = 4'd8,
    OP_XOR    = 4'd9,
    OP_SLT    = 4'd10,
    OP_SLTU   = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'd0,
    CTRL_OR   = 4'd1,
    CTRL_XOR  = 4'd2,
    CTRL_NOR  = 4'd3,
    CTRL_ADD  = 4'd4,
    CTRL_SUB  = 4'd5,
    CTRL_SLT  = 4'd6,
    CTRL_SLTU = 4'd7,
    CTRL_SLL  = 4'd8,
    CTRL_SRL  = 4'd9,
    CTRL_SRA  = 4'd10,
    CTRL_NE   = 4'd11,
    CTRL_LTZ  = 4'd12,
    CTRL_GEZ  = 4'd13,
    CTRL_LEZ  = 4'd14,
    CTRL_GTZ  = 4'd15
  } alu_ctrl_e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/exec_alu_decode.sv
// Maps the control unit's alu_op class (plus funct / REGIMM rt bits) onto
// one of the sixteen ALU control codes.
module exec_alu_decode
  import mips_exec_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic [5:0] func_code,
  input  logic       branchz_bit,
  output alu_ctrl_e  alu_ctrl
);

  alu_ctrl_e w_func_ctrl;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
    w_func_ctrl = CTRL_ADD;
    case (func_code)
      FN_SLL,  FN_SLLV: w_func_ctrl = CTRL_SLL;
      FN_SRL,  FN_SRLV: w_func_ctrl = CTRL_SRL;
      FN_SRA,  FN_SRAV: w_func_ctrl = CTRL_SRA;
      FN_ADD,  FN_ADDU: w_func_ctrl = CTRL_ADD;
      FN_SUB,  FN_SUBU: w_func_ctrl = CTRL_SUB;
      FN_AND:           w_func_ctrl = CTRL_AND;
      FN_OR:            w_func_ctrl = CTRL_OR;
      FN_XOR:           w_func_ctrl = CTRL_XOR;
      FN_NOR:           w_func_ctrl = CTRL_NOR;
      FN_SLT:           w_func_ctrl = CTRL_SLT;
      FN_SLTU:          w_func_ctrl = CTRL_SLTU;
      default:          w_func_ctrl = CTRL_ADD;
    endcase
  end

  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (alu_op)
      OP_ADD:    alu_ctrl = CTRL_ADD;
      OP_RTYPE:  alu_ctrl = w_func_ctrl;
      OP_SUB:    alu_ctrl = CTRL_SUB;
      OP_NE:     alu_ctrl = CTRL_NE;
      OP_REGIMM: alu_ctrl = branchz_bit ? CTRL_GEZ : CTRL_LTZ;
      OP_LEZ:    alu_ctrl = CTRL_LEZ;
      OP_GTZ:    alu_ctrl = CTRL_GTZ;
      OP_AND:    alu_ctrl = CTRL_AND;
      OP_OR:     alu_ctrl = CTRL_OR;
      OP_XOR:    alu_ctrl = CTRL_XOR;
      OP_SLT:    alu_ctrl = CTRL_SLT;
      OP_SLTU:   alu_ctrl = CTRL_SLTU;
      default:   alu_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// Execute stage: combinational ALU, zero flag and branch-target adder, with
// the ALUOut register holding a copy of each for the next multicycle step.
module mips_exec_unit
  import mips_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  func_code,
  input  logic [4:0]  branchz_func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc_out,
  input  logic [31:0] shift_out,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] add_out,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic [31:0] add_out_q
);

  alu_ctrl_e   w_ctrl;
  logic        w_a_is_zero;
  logic [31:0] w_result;
  logic        w_unused_bz;

  // Only the GEZ/LTZ selector bit of the REGIMM rt field matters here.
  assign w_unused_bz = ^branchz_func[4:1];

  exec_alu_decode u_decode (
    .alu_op      (alu_op),
    .func_code   (func_code),
    .branchz_bit (branchz_func[0]),
    .alu_ctrl    (w_ctrl)
  );

  assign w_a_is_zero = (a == 32'd0);

  // Branch codes produce 0 when taken so the zero flag doubles as "take branch".
  always_comb begin
    w_result = 32'd0;
    case (w_ctrl)
      CTRL_AND:  w_result = a & b;
      CTRL_OR:   w_result = a | b;
      CTRL_XOR:  w_result = a ^ b;
      CTRL_NOR:  w_result = ~(a | b);
      CTRL_ADD:  w_result = a + b;
      CTRL_SUB:  w_result = a - b;
      CTRL_SLT:  w_result = {31'd0, $signed(a) < $signed(b)};
      CTRL_SLTU: w_result = {31'd0, a < b};
      CTRL_SLL:  w_result = b << a[4:0];
      CTRL_SRL:  w_result = b >> a[4:0];
      CTRL_SRA:  w_result = $unsigned($signed(b) >>> a[4:0]);
      CTRL_NE:   w_result = {31'd0, a == b};
      CTRL_LTZ:  w_result = {31'd0, ~a[31]};
      CTRL_GEZ:  w_result = {31'd0, a[31]};
      CTRL_LEZ:  w_result = {31'd0, ~(a[31] | w_a_is_zero)};
      CTRL_GTZ:  w_result = {31'd0, a[31] | w_a_is_zero};
      default:   w_result = a + b;
    endcase
  end

  assign alu_ctrl = w_ctrl;
  assign result   = w_result;
  assign zero     = (w_result == 32'd0);
  assign add_out  = pc_out + shift_out;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      result_q  <= 32'd0;
      zero_q    <= 1'b0;
      add_out_q <= 32'd0;
    end else begin
      result_q  <= result;
      zero_q    <= zero;
      add_out_q <= add_out;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed self-checking bench for mips_exec_unit: each step pushes its
// expected outputs to a scoreboard, compared combinationally and after capture.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_op;
  logic [5:0]  func_code;
  logic [4:0]  branchz_func;
  logic [31:0] a, b, pc_out, shift_out;
  logic [3:0]  alu_ctrl;
  logic [31:0] result, add_out, result_q, add_out_q;
  logic        zero, zero_q;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic [31:0] add;
  } exp_t;

  exp_t sb[$];

  mips_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_op       (alu_op),
    .func_code    (func_code),
    .branchz_func (branchz_func),
    .a            (a),
    .b            (b),
    .pc_out       (pc_out),
    .shift_out    (shift_out),
    .alu_ctrl     (alu_ctrl),
    .result       (result),
    .zero         (zero),
    .add_out      (add_out),
    .result_q     (result_q),
    .zero_q       (zero_q),
    .add_out_q    (add_out_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, push expectation, check the combinational path.
  task automatic drive(input string tag, input logic [3:0] op, input logic [5:0] fn,
                       input logic [4:0] bz, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] pc, input logic [31:0] sh,
                       input logic [3:0] e_ctrl, input logic [31:0] e_res,
                       input logic e_z, input logic [31:0] e_add);
    exp_t e;
    @(negedge clk);
    alu_op = op; func_code = fn; branchz_func = bz;
    a = va; b = vb; pc_out = pc; shift_out = sh;
    e.tag = tag; e.ctrl = e_ctrl; e.res = e_res; e.z = e_z; e.add = e_add;
    sb.push_back(e);
    #1;
    check({tag, ".ctrl"},   {28'd0, alu_ctrl}, {28'd0, sb[0].ctrl});
    check({tag, ".result"}, result,            sb[0].res);
    check({tag, ".zero"},   {31'd0, zero},     {31'd0, sb[0].z});
    check({tag, ".add"},    add_out,           sb[0].add);
  endtask

  // After the next rising edge the registers must hold the oldest expectation.
  task automatic capture();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".result_q"},  result_q,          e.res);
      check({e.tag, ".zero_q"},    {31'd0, zero_q},    {31'd0, e.z});
      check({e.tag, ".add_out_q"}, add_out_q,         e.add);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [5:0] fn,
                      input logic [4:0] bz, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] pc, input logic [31:0] sh,
                      input logic [3:0] e_ctrl, input logic [31:0] e_res,
                      input logic e_z, input logic [31:0] e_add);
    drive(tag, op, fn, bz, va, vb, pc, sh, e_ctrl, e_res, e_z, e_add);
    capture();
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, ".result_q"},  result_q,         32'd0);
    check({tag, ".zero_q"},    {31'd0, zero_q},  32'd0);
    check({tag, ".add_out_q"}, add_out_q,        32'd0);
  endtask

  initial begin
    reset = 1'b1;
    alu_op = 4'd0; func_code = 6'd0; branchz_func = 5'd0;
    a = 32'd0; b = 32'd0; pc_out = 32'd0; shift_out = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_regs_zero("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // R-type
    step("addu_wrap", 4'd1, 6'h21, 5'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 4'd4, 32'h80000000, 1'b0, 32'd0);
    step("subu_eq",   4'd1, 6'h23, 5'd0, 32'd5, 32'd5, 32'd0, 32'd0, 4'd5, 32'd0, 1'b1, 32'd0);
    step("sub_neg",   4'd1, 6'h22, 5'd0, 32'd0, 32'd1, 32'd0, 32'd0, 4'd5, 32'hFFFFFFFF, 1'b0, 32'd0);
    step("slt_fn",    4'd1, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd6, 32'd1, 1'b0, 32'd0);
    step("sltu_fn",   4'd1, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd7, 32'd0, 1'b1, 32'd0);
    step("nor_fn",    4'd1, 6'h27, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd3, 32'hFFFFFFFF, 1'b0, 32'd0);
    step("and_fn",    4'd1, 6'h24, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 4'd0, 32'hF000F000, 1'b0, 32'd0);
    step("xor_fn",    4'd1, 6'h26, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 4'd2, 32'h0FF00FF0, 1'b0, 32'd0);
    // Shifts
    step("sra_fn",    4'd1, 6'h03, 5'd0, 32'd4, 32'h80000000, 32'd0, 32'd0, 4'd10, 32'hF8000000, 1'b0, 32'd0);
    step("sll_31",    4'd1, 6'h00, 5'd0, 32'd31, 32'd1, 32'd0, 32'd0, 4'd8, 32'h80000000, 1'b0, 32'd0);
    step("srlv_fn",   4'd1, 6'h06, 5'd0, 32'h00000028, 32'h0000FF00, 32'd0, 32'd0, 4'd9, 32'h000000FF, 1'b0, 32'd0);
    // Branches
    step("bne_eq",    4'd3, 6'h00, 5'd0, 32'd3, 32'd3, 32'd0, 32'd0, 4'd11, 32'd1, 1'b0, 32'd0);
    step("bne_ne",    4'd3, 6'h00, 5'd0, 32'd3, 32'd4, 32'd0, 32'd0, 4'd11, 32'd0, 1'b1, 32'd0);
    step("beq_eq",    4'd2, 6'h00, 5'd0, 32'd9, 32'd9, 32'd0, 32'd0, 4'd5, 32'd0, 1'b1, 32'd0);
    step("bgez_0",    4'd4, 6'h00, 5'b10001, 32'd0, 32'd7, 32'd0, 32'd0, 4'd13, 32'd0, 1'b1, 32'd0);
    step("bltz_0",    4'd4, 6'h00, 5'b00000, 32'd0, 32'd7, 32'd0, 32'd0, 4'd12, 32'd1, 1'b0, 32'd0);
    step("bltz_neg",  4'd4, 6'h00, 5'b10000, 32'h80000000, 32'd0, 32'd0, 32'd0, 4'd12, 32'd0, 1'b1, 32'd0);
    step("blez_0",    4'd5, 6'h00, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 4'd14, 32'd0, 1'b1, 32'd0);
    step("blez_pos",  4'd5, 6'h00, 5'd0, 32'd1, 32'd0, 32'd0, 32'd0, 4'd14, 32'd1, 1'b0, 32'd0);
    step("bgtz_0",    4'd6, 6'h00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd15, 32'd1, 1'b0, 32'd0);
    step("bgtz_pos",  4'd6, 6'h00, 5'd0, 32'd5, 32'h12345678, 32'd0, 32'd0, 4'd15, 32'd0, 1'b1, 32'd0);
    // Immediate classes
    step("or_op",     4'd8, 6'h00, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, 4'd1, 32'hFFF0FFF0, 1'b0, 32'd0);
    step("slti_op",   4'd10, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd6, 32'd1, 1'b0, 32'd0);
    step("sltiu_op",  4'd11, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 4'd7, 32'd0, 1'b1, 32'd0);
    // Branch adder and ADD fallbacks
    step("add_wrap",  4'd0, 6'h00, 5'd0, 32'd10, 32'd20, 32'hFFFFFFFC, 32'd8, 4'd4, 32'd30, 1'b0, 32'd4);
    step("fn_unk",    4'd1, 6'h08, 5'd0, 32'd1, 32'd2, 32'hBFC00000, 32'h10, 4'd4, 32'd3, 1'b0, 32'hBFC00010);
    step("op_unk",    4'd13, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 4'd4, 32'd1, 1'b0, 32'd0);

    // Reset pulse: new inputs land with reset, registers clear, then capture them.
    step("pre_reset", 4'd0, 6'h00, 5'd0, 32'd1, 32'd2, 32'd100, 32'd4, 4'd4, 32'd3, 1'b0, 32'd104);
    reset = 1'b1;
    drive("during_reset", 4'd2, 6'h00, 5'd0, 32'd7, 32'd7, 32'd0, 32'h10, 4'd5, 32'd0, 1'b1, 32'h10);
    @(posedge clk);
    #1;
    check_regs_zero("reset_pulse");
    @(negedge clk);
    reset = 1'b0;
    capture();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
